// File: rtl/dmem_responder.sv
// Data-memory responder for the M stage: one request at a time, fixed wait states.
// Optional byte-lane stores when DMEM_BYTEMASK_EN is defined.
module dmem_responder #(
  parameter int DEPTH       = 256,
  parameter int AW          = 8,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
`ifdef DMEM_BYTEMASK_EN
  input  logic [3:0]  req_be,
`endif
  output logic        req_ready,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        stall_m,
  output logic        busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  localparam logic [3:0] WC = 4'(WAIT_CYCLES);

  state_t      state;
  state_t      next_state;
  logic [3:0]  cnt;
  logic        cap_write;
  logic [31:0] cap_addr;
  logic [31:0] mem [DEPTH];

  logic        accept;
  logic        enter_resp;
  logic [31:0] dec_addr;
  logic        dec_write;
  logic        dec_err;
  logic [AW-1:0] dec_idx;

  // In IDLE decode the live request (accept edge), afterwards the captured one.
  assign dec_addr  = (state == S_IDLE) ? req_addr : cap_addr;
  assign dec_write = (state == S_IDLE) ? req_write : cap_write;
  assign dec_idx   = dec_addr[AW+1:2];
  assign dec_err   = (dec_addr[1:0] != 2'b00) |
                     (dec_addr[31:AW+2] != '0);

  assign accept     = reset & (state == S_IDLE) & req_valid;
  assign enter_resp = (next_state == S_RESP) & (state != S_RESP);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE: begin
        if (req_valid) begin
          next_state = (WC == 4'd0) ? S_RESP : S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt <= 4'd1) begin
          next_state = S_RESP;
        end
      end
      S_RESP:  next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  always_comb begin
    req_ready  = 1'b0;
    busy       = 1'b1;
    resp_valid = 1'b0;
    case (state)
      S_IDLE: begin
        req_ready = 1'b1;
        busy      = 1'b0;
      end
      S_RESP:  resp_valid = 1'b1;
      default: ;
    endcase
  end

  assign stall_m = (req_valid & ~resp_valid) | (busy & ~resp_valid);

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt       <= 4'd0;
      cap_write <= 1'b0;
      cap_addr  <= 32'd0;
    end else if (accept) begin
      cnt       <= WC;
      cap_write <= req_write;
      cap_addr  <= req_addr;
    end else if (state == S_WAIT) begin
      cnt <= cnt - 4'd1;
    end
  end

  // Stores commit at the accept edge; the array has no reset.
  always_ff @(posedge clk) begin
    if (accept & req_write & ~dec_err) begin
`ifdef DMEM_BYTEMASK_EN
      for (int i = 0; i < 4; i++) begin
        if (req_be[i]) begin
          mem[dec_idx][8*i +: 8] <= req_wdata[8*i +: 8];
        end
      end
`else
      mem[dec_idx] <= req_wdata;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      resp_err   <= 1'b0;
      resp_rdata <= 32'd0;
    end else if (enter_resp) begin
      resp_err   <= dec_err;
      resp_rdata <= (dec_write | dec_err) ? 32'd0 : mem[dec_idx];
    end else begin
      resp_err   <= 1'b0;
      resp_rdata <= 32'd0;
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: vector table plus reset,
// field-scramble and back-to-back throughput sequences.
module tb_dmem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        a_valid, a_write;
  logic [31:0] a_addr, a_wdata;
  logic        a_ready, a_rvalid, a_err, a_stall, a_busy;
  logic [31:0] a_rdata;
  logic        b_valid, b_write;
  logic [31:0] b_addr, b_wdata;
  logic        b_ready, b_rvalid, b_err, b_stall, b_busy;
  logic [31:0] b_rdata;
`ifdef DMEM_BYTEMASK_EN
  logic [3:0]  a_be;
  logic [3:0]  b_be;
`endif

  dmem_responder #(.DEPTH(256), .AW(8), .WAIT_CYCLES(2)) dut_a (
    .clk(clk), .reset(reset),
    .req_valid(a_valid), .req_write(a_write),
    .req_addr(a_addr), .req_wdata(a_wdata),
`ifdef DMEM_BYTEMASK_EN
    .req_be(a_be),
`endif
    .req_ready(a_ready), .resp_valid(a_rvalid),
    .resp_rdata(a_rdata), .resp_err(a_err),
    .stall_m(a_stall), .busy(a_busy)
  );

  dmem_responder #(.DEPTH(256), .AW(8), .WAIT_CYCLES(0)) dut_b (
    .clk(clk), .reset(reset),
    .req_valid(b_valid), .req_write(b_write),
    .req_addr(b_addr), .req_wdata(b_wdata),
`ifdef DMEM_BYTEMASK_EN
    .req_be(b_be),
`endif
    .req_ready(b_ready), .resp_valid(b_rvalid),
    .resp_rdata(b_rdata), .resp_err(b_err),
    .stall_m(b_stall), .busy(b_busy)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        err;
    logic [31:0] rdata;
  } vec_t;

  vec_t vecs[12];

  task automatic a_txn(input logic wr, input logic [31:0] addr,
                       input logic [31:0] wdata, output logic err,
                       output logic [31:0] rdata, output int lat);
    logic found;
    found = 1'b0;
    err   = 1'b0;
    rdata = 32'd0;
    lat   = 0;
    @(negedge clk);
    a_valid = 1'b1;
    a_write = wr;
    a_addr  = addr;
    a_wdata = wdata;
    #1;
    chk("req_stall", a_stall, 1);
    chk("req_ready", a_ready, 1);
    @(posedge clk);
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      lat++;
      if (a_rvalid) begin
        err   = a_err;
        rdata = a_rdata;
        found = 1'b1;
        chk("resp_stall", a_stall, 0);
        chk("resp_ready", a_ready, 0);
        a_valid = 1'b0;
        break;
      end else begin
        chk("wait_rdata", a_rdata, 0);
        chk("wait_err", a_err, 0);
        chk("wait_stall", a_stall, 1);
      end
    end
    chk("resp_seen", found, 1);
  endtask

  logic        e;
  logic [31:0] d;
  int          l;
  int          pulses, accepts, consec, bad, stray;
  logic        prev;
  logic        found;

  initial begin
    vecs[0]  = '{1'b1, 32'h10,       32'hDEADBEEF, 1'b0, 32'h0};
    vecs[1]  = '{1'b0, 32'h10,       32'h0,        1'b0, 32'hDEADBEEF};
    vecs[2]  = '{1'b1, 32'h13,       32'h12345678, 1'b1, 32'h0};
    vecs[3]  = '{1'b0, 32'h10,       32'h0,        1'b0, 32'hDEADBEEF};
    vecs[4]  = '{1'b0, 32'h400,      32'h0,        1'b1, 32'h0};
    vecs[5]  = '{1'b1, 32'h3FC,      32'hCAFEF00D, 1'b0, 32'h0};
    vecs[6]  = '{1'b0, 32'h3FC,      32'h0,        1'b0, 32'hCAFEF00D};
    vecs[7]  = '{1'b1, 32'h0,        32'h11112222, 1'b0, 32'h0};
    vecs[8]  = '{1'b0, 32'h0,        32'h0,        1'b0, 32'h11112222};
    vecs[9]  = '{1'b1, 32'h80000010, 32'h99999999, 1'b1, 32'h0};
    vecs[10] = '{1'b0, 32'h10,       32'h0,        1'b0, 32'hDEADBEEF};
    vecs[11] = '{1'b0, 32'h2,        32'h0,        1'b1, 32'h0};

    reset   = 1'b0;
    a_valid = 1'b0; a_write = 1'b0; a_addr = '0; a_wdata = '0;
    b_valid = 1'b0; b_write = 1'b0; b_addr = '0; b_wdata = '0;
`ifdef DMEM_BYTEMASK_EN
    a_be = 4'hF;
    b_be = 4'hF;
`endif
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", a_ready, 1);
    chk("rst_busy", a_busy, 0);
    chk("rst_rvalid", a_rvalid, 0);
    chk("rst_rdata", a_rdata, 0);
    chk("rst_err", a_err, 0);
    chk("rst_stall", a_stall, 0);
    chk("rst_b_rvalid", b_rvalid, 0);
    reset = 1'b1;

    for (int i = 0; i < 12; i++) begin
      a_txn(vecs[i].wr, vecs[i].addr, vecs[i].wdata, e, d, l);
      chk($sformatf("v%0d_lat", i), l, 3);
      chk($sformatf("v%0d_err", i), e, vecs[i].err);
      chk($sformatf("v%0d_rdata", i), d, vecs[i].rdata);
    end

    // Drop valid and scramble fields right after accept.
    @(negedge clk);
    a_valid = 1'b1; a_write = 1'b1;
    a_addr = 32'h20; a_wdata = 32'hAAAA5555;
    @(posedge clk);
    found = 1'b0;
    l = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      a_valid = 1'b0; a_write = 1'b0;
      a_addr = 32'h24; a_wdata = 32'h0;
      l++;
      if (a_rvalid) begin
        found = 1'b1;
        chk("scr_err", a_err, 0);
        break;
      end
    end
    chk("scr_seen", found, 1);
    chk("scr_lat", l, 3);
    a_txn(1'b0, 32'h20, 32'h0, e, d, l);
    chk("scr_load", d, 32'hAAAA5555);

    // Reset while in WAIT.
    @(negedge clk);
    a_valid = 1'b1; a_write = 1'b1;
    a_addr = 32'h30; a_wdata = 32'h0BADF00D;
    @(posedge clk);
    @(negedge clk);
    chk("mid_busy_pre", a_busy, 1);
    a_valid = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    chk("mid_busy", a_busy, 0);
    chk("mid_ready", a_ready, 1);
    chk("mid_rvalid", a_rvalid, 0);
    reset = 1'b1;
    stray = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (a_rvalid) stray++;
    end
    chk("mid_stray", stray, 0);
    a_txn(1'b0, 32'h30, 32'h0, e, d, l);
    chk("mid_load", d, 32'h0BADF00D);

`ifdef DMEM_BYTEMASK_EN
    a_be = 4'b0001;
    a_txn(1'b1, 32'h10, 32'h00000055, e, d, l);
    chk("be_err", e, 0);
    a_be = 4'b0000;
    a_txn(1'b1, 32'h10, 32'hFFFFFFFF, e, d, l);
    chk("be0_err", e, 0);
    a_be = 4'b0000;
    a_txn(1'b0, 32'h10, 32'h0, e, d, l);
    chk("be_load", d, 32'hDEADBE55);
    a_be = 4'hF;
`endif

    // Back-to-back with zero wait states.
    @(negedge clk);
    b_valid = 1'b1; b_write = 1'b1;
    b_addr = 32'h10; b_wdata = 32'h01020304;
    pulses = 0; accepts = 0; consec = 0; bad = 0;
    prev = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      if (b_rvalid) pulses++;
      if (b_rvalid && prev) consec++;
      if (b_ready === b_rvalid) bad++;
      if (b_stall !== ~b_rvalid) bad++;
      if (b_ready && b_valid) accepts++;
      prev = b_rvalid;
    end
    b_valid = 1'b0;
    chk("tp_pulses", pulses, 6);
    chk("tp_accepts", accepts, 6);
    chk("tp_consec", consec, 0);
    chk("tp_ready_stall", bad, 0);

    @(negedge clk);
    b_valid = 1'b1; b_write = 1'b0; b_addr = 32'h10;
    @(posedge clk);
    @(negedge clk);
    chk("w0_rvalid", b_rvalid, 1);
    chk("w0_rdata", b_rdata, 32'h01020304);
    chk("w0_err", b_err, 0);
    b_valid = 1'b0;
    @(negedge clk);
    chk("w0_after", b_rvalid, 0);
    chk("w0_after_rdata", b_rdata, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
